// File: rtl/uart_reg_bridge_if.sv
// UART FIFO and register-bus signals shared by the bridge and its surroundings.
// The bridge connects through the master modport; the FIFO/register side uses slave.
interface uart_reg_bridge_if #(
    parameter int unsigned DBIT = 8
);
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rd_uart;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;
    logic            tx_full;
    logic [DBIT-2:0] reg_addr;
    logic [DBIT-1:0] reg_wdata;
    logic            reg_we;
    logic            reg_re;
    logic [DBIT-1:0] reg_rdata;

    modport master (
        input  r_data, rx_empty, tx_full, reg_rdata,
        output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output r_data, rx_empty, tx_full, reg_rdata,
        input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// UART command engine: pops read/write command bytes from the RX FIFO, performs one
// register-bus access per command and pushes one reply byte into the TX FIFO.
module uart_reg_bridge #(
    parameter int unsigned DBIT           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TMR_W          = 17,
    parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
    input  logic               clk,
    input  logic               reset,
    uart_reg_bridge_if.master  bus,
    output logic               busy,
    output logic               err_timeout
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StGetData = 3'd1;
    localparam logic [2:0] StBusWr   = 3'd2;
    localparam logic [2:0] StBusRd   = 3'd3;
    localparam logic [2:0] StRdWait  = 3'd4;
    localparam logic [2:0] StSend    = 3'd5;

    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [DBIT-2:0] addr_q, addr_d;
    logic [DBIT-1:0] data_q, data_d;
    logic [DBIT-1:0] reply_q, reply_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic rd_c, wr_c, we_c, re_c, to_c;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        reply_d = reply_q;
        timer_d = timer_q;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        to_c    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus.rx_empty) begin
                    rd_c    = 1'b1;
                    addr_d  = bus.r_data[DBIT-2:0];
                    state_d = bus.r_data[DBIT-1] ? StGetData : StBusRd;
                end
            end
            StGetData: begin
                // A data byte present in the timeout cycle is still accepted.
                if (!bus.rx_empty) begin
                    rd_c    = 1'b1;
                    data_d  = bus.r_data;
                    timer_d = '0;
                    state_d = StBusWr;
                end else if (timer_q == TmrLast) begin
                    to_c    = 1'b1;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StBusWr: begin
                we_c    = 1'b1;
                reply_d = ACK_BYTE;
                state_d = StSend;
            end
            StBusRd: begin
                re_c    = 1'b1;
                state_d = StRdWait;
            end
            StRdWait: begin
                reply_d = bus.reg_rdata;
                state_d = StSend;
            end
            StSend: begin
                if (!bus.tx_full) begin
                    wr_c    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            reply_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            reply_q <= reply_d;
            timer_q <= timer_d;
        end
    end

    // Reset leaves the state in IDLE, so the pop strobe must be masked while it is held.
    assign bus.rd_uart   = rd_c & ~reset;
    assign bus.wr_uart   = wr_c;
    assign bus.reg_we    = we_c;
    assign bus.reg_re    = re_c;
    assign bus.w_data    = reply_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = data_q;
    assign busy          = (state_q != StIdle);
    assign err_timeout   = to_c;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: a command-level model predicts bus accesses,
// replies and timeouts; a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_reg_bridge;
    localparam int unsigned Timeout = 10;
    localparam logic [7:0]  Ack     = 8'h06;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } bus_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, err_timeout;

    uart_reg_bridge_if #(.DBIT(8)) bif ();

    uart_reg_bridge #(
        .DBIT(8), .TIMEOUT_CYCLES(Timeout), .TMR_W(4), .ACK_BYTE(Ack)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    bus_t       exp_bus[$];
    logic [7:0] exp_reply[$];
    int         exp_to;
    logic [7:0] rx_q[$];
    logic [7:0] slv_mem[128];
    logic [7:0] model_mem[128];

    int vectors, miscompares;
    int cyc, n_push, n_to;
    int pop_cyc, re_cyc, we_cyc, push_cyc, to_cyc;
    logic       cap_pop, cap_re, cap_we;
    logic [6:0] cap_addr;
    logic [7:0] cap_wdata;
    int   tx_mode;
    logic tx_force;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] outs();
        return {3'b0, bif.rd_uart, bif.wr_uart, bif.reg_we, bif.reg_re, busy, err_timeout,
                bif.w_data, bif.reg_addr, bif.reg_wdata};
    endfunction

    // Monitor / scoreboard checker.
    initial begin
        bus_t e;
        cap_pop = 1'b0; cap_re = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cap_pop   = bif.rd_uart;
            cap_re    = bif.reg_re;
            cap_we    = bif.reg_we;
            cap_addr  = bif.reg_addr;
            cap_wdata = bif.reg_wdata;
            if (!reset) begin
                if (bif.rd_uart) begin
                    pop_cyc = cyc;
                    check("pop_has_byte", {31'b0, bif.rx_empty}, 32'd0);
                end
                if (bif.reg_we || bif.reg_re) begin
                    if (bif.reg_we) we_cyc = cyc;
                    if (bif.reg_re) re_cyc = cyc;
                    if (exp_bus.size() == 0) begin
                        check("unexpected_bus", {30'b0, bif.reg_we, bif.reg_re}, 32'd0);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_txn",
                              {14'b0, bif.reg_we, bif.reg_re, 1'b0, bif.reg_addr,
                               bif.reg_we ? bif.reg_wdata : 8'h00},
                              {14'b0, e.we, ~e.we, 1'b0, e.addr, e.we ? e.data : 8'h00});
                    end
                end
                if (bif.wr_uart) begin
                    n_push++;
                    push_cyc = cyc;
                    if (exp_reply.size() == 0)
                        check("unexpected_push", {31'b0, bif.wr_uart}, 32'd0);
                    else
                        check("reply", {24'b0, bif.w_data}, {24'b0, exp_reply.pop_front()});
                end
                if (err_timeout) begin
                    n_to++;
                    to_cyc = cyc;
                    if (exp_to == 0) check("unexpected_timeout", {31'b0, err_timeout}, 32'd0);
                    else exp_to--;
                end
            end
        end
    end

    task automatic refresh();
        bif.rx_empty = (rx_q.size() == 0);
        bif.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // One clock of FIFO / register-slave environment, applied just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            if (cap_pop && rx_q.size() != 0) void'(rx_q.pop_front());
            if (cap_we) slv_mem[cap_addr] = cap_wdata;
        end
        bif.reg_rdata = (!reset && cap_re) ? slv_mem[cap_addr] : 8'($urandom);
        bif.tx_full   = (tx_mode != 0) ? ($urandom_range(0, 2) == 0) : tx_force;
        refresh();
    endtask

    // Reference model: one command = one expected bus access and one expected reply.
    task automatic model_cmd(logic [7:0] cmd, logic [7:0] data);
        if (cmd[7]) begin
            exp_bus.push_back('{we: 1'b1, addr: cmd[6:0], data: data});
            model_mem[cmd[6:0]] = data;
            exp_reply.push_back(Ack);
        end else begin
            exp_bus.push_back('{we: 1'b0, addr: cmd[6:0], data: 8'h00});
            exp_reply.push_back(model_mem[cmd[6:0]]);
        end
    endtask

    task automatic issue(logic [7:0] cmd, logic [7:0] data);
        model_cmd(cmd, data);
        rx_q.push_back(cmd);
        if (cmd[7]) rx_q.push_back(data);
        refresh();
    endtask

    task automatic drain(string name);
        int n = 0;
        while (!(rx_q.size() == 0 && exp_reply.size() == 0 && exp_bus.size() == 0 &&
                 exp_to == 0 && !busy) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_drained"}, {31'b0, n < 3000}, 32'd1);
    endtask

    initial begin
        int p0, t0;
        logic [7:0] c;
        for (int i = 0; i < 128; i++) begin
            slv_mem[i]   = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        tx_mode = 0; tx_force = 1'b0; exp_to = 0;
        bif.tx_full = 1'b0; bif.reg_rdata = 8'h00;
        refresh();
        #2;
        check("reset_outputs", outs(), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // Write 0x85/0x3C.
        issue(8'h85, 8'h3C);
        drain("wr1");
        check("wr_we_to_push", 32'(push_cyc - we_cyc), 32'd1);
        check("wr_datapop_to_push", 32'(push_cyc - pop_cyc), 32'd2);
        check("wr_busy_idle", {31'b0, busy}, 32'd0);

        // Read 0x12 returning 0xA7.
        issue(8'h92, 8'hA7);
        drain("wr2");
        issue(8'h12, 8'h00);
        drain("rd1");
        check("rd_re_to_push", 32'(push_cyc - re_cyc), 32'd2);
        check("rd_pop_to_push", 32'(push_cyc - pop_cyc), 32'd3);

        // Missing write data: timeout, no reply, then a normal read.
        p0 = n_push; t0 = n_to;
        rx_q.push_back(8'h81); refresh();
        exp_to++;
        drain("timeout");
        check("timeout_count", 32'(n_to - t0), 32'd1);
        check("timeout_delay", 32'(to_cyc - pop_cyc), 32'd10);
        check("timeout_no_push", 32'(n_push), 32'(p0));
        issue(8'h01, 8'h00);
        drain("after_timeout");
        check("after_timeout_push", 32'(n_push - p0), 32'd1);

        // Data byte arriving in the timeout cycle wins.
        t0 = n_to;
        model_cmd(8'hC4, 8'h5C);
        rx_q.push_back(8'hC4); refresh();
        repeat (10) tick();
        rx_q.push_back(8'h5C); refresh();
        drain("late_byte");
        check("late_byte_no_timeout", 32'(n_to - t0), 32'd0);

        // TX full holds the reply.
        tx_force = 1'b1; tick();
        p0 = n_push;
        issue(8'h05, 8'h00);
        repeat (50) tick();
        check("hold_busy", {31'b0, busy}, 32'd1);
        check("hold_no_push", 32'(n_push), 32'(p0));
        tx_force = 1'b0;
        drain("hold");
        check("hold_one_push", 32'(n_push - p0), 32'd1);

        // Six queued bytes: 85 3C 05 81 FF 01.
        p0 = n_push;
        issue(8'h85, 8'h3C); issue(8'h05, 8'h00); issue(8'h81, 8'hFF); issue(8'h01, 8'h00);
        drain("burst");
        check("burst_pushes", 32'(n_push - p0), 32'd4);

        // Reset during GET_DATA.
        rx_q.push_back(8'h81); refresh();
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 check("reset_in_get_data", outs(), 32'd0);
        rx_q.delete(); refresh();
        repeat (2) tick();
        #2 reset = 1'b0;
        repeat (15) tick();
        issue(8'h83, 8'h11);
        drain("post_reset1");

        // Reset during SEND with another byte waiting in the RX FIFO.
        tx_force = 1'b1; tick();
        issue(8'h03, 8'h00);
        rx_q.push_back(8'h33); refresh();
        repeat (6) tick();
        check("send_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_in_send", outs(), 32'd0);
        rx_q.delete(); exp_reply.delete(); exp_bus.delete(); refresh();
        tx_force = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b0;
        p0 = n_push;
        repeat (10) tick();
        check("reset_no_push", 32'(n_push), 32'(p0));
        issue(8'h03, 8'h00);
        drain("post_reset2");

        // Randomized traffic with random TX back-pressure.
        tx_mode = 1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            c = 8'($urandom);
            issue(c, 8'($urandom));
        end
        drain("random");
        tx_mode = 0;
        drain("final");
        check("timeouts_all_seen", 32'(exp_to), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
